mdi_register_bank: RTL and testbench

Parametrised bank of DEPTH read-once collapse cells in the MDI-QKD style, with an integrated basis matcher and a valid/ready read port. Each cell holds a value and a prepared basis. The first measurement of a live cell collapses it whatever the basis. Only a matching-basis measurement returns the true value; every other read returns LFSR obfuscation. The block sits between the host measurement interface and the per-cell OTP/antifuse kill logic, replacing single-cell registers wired to a standalone matcher.

---
 rtl/mdi_pkg.sv | 28 ++
 rtl/mdi_lfsr.sv | 23 ++
 rtl/mdi_register_bank.sv | 185 ++++++++++++++++++
 tb/tb_mdi_register_bank.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdi_pkg.sv
// Shared types and constants for the MDI read-once register bank.
package mdi_pkg;

    // Lifecycle of a single collapse cell.
    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        ARMED     = 2'd1,
        COLLAPSED = 2'd2,
        FUSED     = 2'd3
    } cell_state_t;

    // Measurement port sequencing.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        RESP    = 2'd2
    } rd_state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps: bit7 ^ bit5 ^ bit4 ^ bit3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // One left shift of the obfuscation LFSR.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mdi_lfsr.sv
// Free-running 8-bit obfuscation source; shifts every cycle from the seed.
module mdi_lfsr
    import mdi_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_reg;

    // Advance the LFSR each cycle; reset reloads the seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign lfsr = lfsr_reg;

endmodule

// File: rtl/mdi_register_bank.sv
// Bank of read-once collapse cells with inline basis matcher and a
// valid/ready measurement port. Only a matching first read sees the value.
module mdi_register_bank
    import mdi_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int WIDTH   = 8,
    parameter  int BASIS_W = 2,
    parameter  int REARM   = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init,
    input  logic [ADDR_W-1:0]  init_addr,
    input  logic [WIDTH-1:0]   init_value,
    input  logic [BASIS_W-1:0] init_basis,
    output logic               init_err,
    input  logic               rd_valid,
    output logic               rd_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [BASIS_W-1:0] rd_basis,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_data,
    output logic               resp_match,
    output logic               pad_enable,
    input  logic [DEPTH-1:0]   fuse_blow,
    output logic [DEPTH-1:0]   collapsed,
    output logic [DEPTH-1:0]   killed,
    output logic               fuse_fire,
    output logic [ADDR_W-1:0]  fuse_fire_addr
);

    cell_state_t        cell_state_reg [DEPTH];
    logic [WIDTH-1:0]   cell_value_reg [DEPTH];
    logic [BASIS_W-1:0] cell_basis_reg [DEPTH];

    rd_state_t          rd_state_reg, rd_state_next;
    logic [ADDR_W-1:0]  rd_addr_reg;
    logic [BASIS_W-1:0] rd_basis_reg;
    logic [WIDTH-1:0]   resp_data_reg;
    logic               resp_match_reg;
    logic               fire_reg;
    logic [ADDR_W-1:0]  fire_addr_reg;
    logic               init_err_reg;

    logic [7:0]         lfsr;

    cell_state_t        meas_state, init_state;
    logic [WIDTH-1:0]   meas_value;
    logic [BASIS_W-1:0] meas_basis;
    logic               meas_fuse, init_fuse, init_in_range;
    logic               live, match, init_collide, init_accept;

    mdi_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    // Select the cell under measurement and the cell targeted by init.
    always_comb begin
        meas_state    = EMPTY;
        meas_value    = '0;
        meas_basis    = '0;
        meas_fuse     = 1'b0;
        init_state    = EMPTY;
        init_fuse     = 1'b0;
        init_in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_reg == ADDR_W'(i)) begin
                meas_state = cell_state_reg[i];
                meas_value = cell_value_reg[i];
                meas_basis = cell_basis_reg[i];
                meas_fuse  = fuse_blow[i];
            end
            if (init_addr == ADDR_W'(i)) begin
                init_state    = cell_state_reg[i];
                init_fuse     = fuse_blow[i];
                init_in_range = 1'b1;
            end
        end
    end

    // A measurement collapses only an ARMED cell not being fused this edge;
    // a same-edge init to that cell loses to the collapse.
    always_comb begin
        live         = (rd_state_reg == MEASURE) && (meas_state == ARMED) && !meas_fuse;
        match        = live && (rd_basis_reg == meas_basis);
        init_collide = live && (init_addr == rd_addr_reg);
        init_accept  = init && init_in_range && !init_fuse && !init_collide &&
                       ((init_state == EMPTY) || (init_state == ARMED) ||
                        ((init_state == COLLAPSED) && (REARM != 0)));
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic hit_collapse;
            logic hit_init;

            assign hit_collapse = live && (rd_addr_reg == ADDR_W'(gi));
            assign hit_init     = init_accept && (init_addr == ADDR_W'(gi));

            // Cell lifecycle: fuse beats collapse beats init.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cell_state_reg[gi] <= EMPTY;
                    cell_value_reg[gi] <= '0;
                    cell_basis_reg[gi] <= '0;
                end else if (fuse_blow[gi]) begin
                    cell_state_reg[gi] <= FUSED;
                    cell_value_reg[gi] <= '0;
                end else if (hit_collapse) begin
                    cell_state_reg[gi] <= COLLAPSED;
                end else if (hit_init) begin
                    cell_state_reg[gi] <= ARMED;
                    cell_value_reg[gi] <= init_value;
                    cell_basis_reg[gi] <= init_basis;
                end
            end

            assign collapsed[gi] = (cell_state_reg[gi] == COLLAPSED);
            assign killed[gi]    = (cell_state_reg[gi] == COLLAPSED) ||
                                   (cell_state_reg[gi] == FUSED);
        end
    endgenerate

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_reg <= IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    // Read FSM next-state: accept, measure for one cycle, hold response.
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            IDLE:    if (rd_valid)   rd_state_next = MEASURE;
            MEASURE:                 rd_state_next = RESP;
            RESP:    if (resp_ready) rd_state_next = IDLE;
            default:                 rd_state_next = IDLE;
        endcase
    end

    // Request capture, response registers and one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_reg    <= '0;
            rd_basis_reg   <= '0;
            resp_data_reg  <= '0;
            resp_match_reg <= 1'b0;
            fire_reg       <= 1'b0;
            fire_addr_reg  <= '0;
            init_err_reg   <= 1'b0;
        end else begin
            fire_reg     <= live;
            init_err_reg <= init && !init_accept;
            if (live) begin
                fire_addr_reg <= rd_addr_reg;
            end
            if ((rd_state_reg == IDLE) && rd_valid) begin
                rd_addr_reg  <= rd_addr;
                rd_basis_reg <= rd_basis;
            end
            if (rd_state_reg == MEASURE) begin
                resp_data_reg  <= match ? meas_value : {(WIDTH/8){lfsr}};
                resp_match_reg <= match;
            end
        end
    end

    assign rd_ready       = (rd_state_reg == IDLE);
    assign resp_valid     = (rd_state_reg == RESP);
    assign resp_data      = resp_data_reg;
    assign resp_match     = resp_match_reg & resp_valid;
    assign pad_enable     = resp_valid & resp_match;
    assign fuse_fire      = fire_reg;
    assign fuse_fire_addr = fire_addr_reg;
    assign init_err       = init_err_reg;

endmodule

// File: tb/tb_mdi_register_bank.sv
// Bench for mdi_register_bank: table of init/read vectors plus hand-written
// collision, fuse, backpressure and reset sequences; responses are checked
// through a scoreboard queue against a reference LFSR.
module tb_mdi_register_bank;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 8;
    localparam int BASIS_W = 2;
    localparam int ADDR_W  = 3;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               init = 1'b0;
    logic [ADDR_W-1:0]  init_addr = '0;
    logic [WIDTH-1:0]   init_value = '0;
    logic [BASIS_W-1:0] init_basis = '0;
    logic               rd_valid = 1'b0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [BASIS_W-1:0] rd_basis = '0;
    logic               resp_ready = 1'b1;
    logic [DEPTH-1:0]   fuse_blow = '0;

    logic               init_err, rd_ready, resp_valid, resp_match, pad_enable, fuse_fire;
    logic [WIDTH-1:0]   resp_data;
    logic [DEPTH-1:0]   collapsed, killed;
    logic [ADDR_W-1:0]  fuse_fire_addr;

    logic               r_init_err, r_rd_ready, r_resp_valid, r_resp_match, r_pad_enable, r_fuse_fire;
    logic [WIDTH-1:0]   r_resp_data;
    logic [DEPTH-1:0]   r_collapsed, r_killed;
    logic [ADDR_W-1:0]  r_fuse_fire_addr;

    always #5 clk = ~clk;

    mdi_register_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BASIS_W(BASIS_W), .REARM(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .init(init), .init_addr(init_addr),
        .init_value(init_value), .init_basis(init_basis), .init_err(init_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_basis(rd_basis),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_match(resp_match), .pad_enable(pad_enable), .fuse_blow(fuse_blow),
        .collapsed(collapsed), .killed(killed), .fuse_fire(fuse_fire),
        .fuse_fire_addr(fuse_fire_addr)
    );

    mdi_register_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BASIS_W(BASIS_W), .REARM(1)) u_dut_rearm (
        .clk(clk), .reset_n(reset_n), .init(init), .init_addr(init_addr),
        .init_value(init_value), .init_basis(init_basis), .init_err(r_init_err),
        .rd_valid(rd_valid), .rd_ready(r_rd_ready), .rd_addr(rd_addr), .rd_basis(rd_basis),
        .resp_valid(r_resp_valid), .resp_ready(resp_ready), .resp_data(r_resp_data),
        .resp_match(r_resp_match), .pad_enable(r_pad_enable), .fuse_blow(fuse_blow),
        .collapsed(r_collapsed), .killed(r_killed), .fuse_fire(r_fuse_fire),
        .fuse_fire_addr(r_fuse_fire_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference obfuscation source: 8'hA5 seed, fb = b7^b5^b4^b3, shift left.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        logic [WIDTH-1:0]  data;
        logic              match;
        logic              fire;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    logic             seen = 1'b0;
    logic [WIDTH-1:0] last_exp_data = '0;
    logic             chk_rearm = 1'b0;

    // Scoreboard monitor: pop one expectation when a response first appears.
    always @(negedge clk) begin
        if (resp_valid && !seen) begin
            seen = 1'b1;
            check("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                $display("resp: data=%0h match=%0b fire=%0b (exp %0h %0b %0b)",
                         resp_data, resp_match, fuse_fire, mon_e.data, mon_e.match, mon_e.fire);
                check("resp_data", resp_data, mon_e.data);
                check("resp_match", resp_match, mon_e.match);
                check("pad_enable", pad_enable, mon_e.match);
                check("fuse_fire", fuse_fire, mon_e.fire);
                if (mon_e.fire) check("fuse_fire_addr", fuse_fire_addr, mon_e.addr);
            end
        end else begin
            if (!resp_valid) seen = 1'b0;
            if (fuse_fire) check("fuse_fire_spurious", fuse_fire, 1'b0);
        end
    end

    task automatic do_init(input int a, input logic [7:0] v, input logic [1:0] b,
                           input logic exp_err, input logic exp_err_r, input string tag);
        @(negedge clk);
        init = 1'b1; init_addr = ADDR_W'(a); init_value = v; init_basis = b;
        @(negedge clk);
        init = 1'b0;
        $display("init %s: addr=%0d val=%0h basis=%0d err=%0b/%0b", tag, a, v, b, init_err, r_init_err);
        check({tag, "_init_err"}, init_err, exp_err);
        check({tag, "_init_err_rearm"}, r_init_err, exp_err_r);
    endtask

    task automatic do_read(input int a, input logic [1:0] b, input logic exp_match,
                           input logic [7:0] exp_val, input logic exp_fire,
                           input int inj_init, input int inj_fuse, input logic exp_inj_err,
                           input string tag);
        exp_t e;
        @(negedge clk);
        check({tag, "_rd_ready"}, rd_ready, 1'b1);
        rd_valid = 1'b1; rd_addr = ADDR_W'(a); rd_basis = b;
        @(negedge clk);
        rd_valid = 1'b0;
        e.data  = exp_match ? exp_val : {(WIDTH/8){m_lfsr}};
        e.match = exp_match;
        e.fire  = exp_fire;
        e.addr  = ADDR_W'(a);
        last_exp_data = e.data;
        sb_q.push_back(e);
        if (inj_init >= 0) begin
            init = 1'b1; init_addr = ADDR_W'(inj_init); init_value = 8'h99; init_basis = b;
        end
        if (inj_fuse >= 0) fuse_blow[inj_fuse] = 1'b1;
        @(negedge clk);
        init = 1'b0; fuse_blow = '0;
        if (inj_init >= 0) check({tag, "_inj_init_err"}, init_err, exp_inj_err);
        for (int k = 0; k < 8 && !resp_valid; k++) @(negedge clk);
        check({tag, "_resp_valid"}, resp_valid, 1'b1);
        if (chk_rearm) begin
            check({tag, "_rearm_data"}, r_resp_data, 8'h77);
            check({tag, "_rearm_match"}, r_resp_match, 1'b1);
            check({tag, "_rearm_fire"}, r_fuse_fire, 1'b1);
        end
        if (resp_ready) begin
            @(negedge clk);
            check({tag, "_resp_done"}, resp_valid, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_ready"}, rd_ready, 1'b1);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_resp_match"}, resp_match, 1'b0);
        check({tag, "_pad_enable"}, pad_enable, 1'b0);
        check({tag, "_fuse_fire"}, fuse_fire, 1'b0);
        check({tag, "_init_err"}, init_err, 1'b0);
        check({tag, "_resp_data"}, resp_data, '0);
        check({tag, "_fire_addr"}, fuse_fire_addr, '0);
        check({tag, "_collapsed"}, collapsed, '0);
        check({tag, "_killed"}, killed, '0);
        check({tag, "_killed_rearm"}, r_killed, '0);
    endtask

    typedef struct {
        bit         rd;
        int         addr;
        logic [7:0] val;
        logic [1:0] basis;
        logic       e_match;
        logic       e_fire;
        logic       e_err;
        logic       e_err_r;
        logic       e_coll;
    } vec_t;

    vec_t vt [11];

    initial begin
        //           rd addr val    basis match fire err err_r coll
        vt[0]  = '{0, 3, 8'h5A, 2'd2, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 3, 8'h5A, 2'd2, 1, 1, 0, 0, 1};
        vt[2]  = '{1, 3, 8'h00, 2'd2, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 0, 8'h11, 2'd1, 0, 0, 0, 0, 0};
        vt[4]  = '{1, 0, 8'h00, 2'd2, 0, 1, 0, 0, 1};
        vt[5]  = '{0, 0, 8'h77, 2'd1, 0, 0, 1, 0, 0};
        vt[6]  = '{1, 6, 8'h00, 2'd0, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 1, 8'hC3, 2'd3, 0, 0, 0, 0, 0};
        vt[8]  = '{1, 1, 8'hC3, 2'd3, 1, 1, 0, 0, 1};
        vt[9]  = '{0, 7, 8'hF0, 2'd0, 0, 0, 0, 0, 0};
        vt[10] = '{1, 7, 8'hF0, 2'd0, 1, 1, 0, 0, 1};

        // Reset state, during reset and on the first cycle after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_low");
        reset_n = 1'b1;
        check_reset_outputs("rst_rel");

        // Table-driven init/read sequence.
        for (int i = 0; i < 11; i++) begin
            if (vt[i].rd) begin
                do_read(vt[i].addr, vt[i].basis, vt[i].e_match, vt[i].val, vt[i].e_fire,
                        -1, -1, 1'b0, $sformatf("vec%0d", i));
                check($sformatf("vec%0d_collapsed", i), collapsed[vt[i].addr], vt[i].e_coll);
                check($sformatf("vec%0d_killed", i), killed[vt[i].addr], vt[i].e_coll);
            end else begin
                do_init(vt[i].addr, vt[i].val, vt[i].basis, vt[i].e_err, vt[i].e_err_r,
                        $sformatf("vec%0d", i));
            end
        end

        // Re-armed cell 0 returns the new value only on the REARM=1 bank.
        chk_rearm = 1'b1;
        do_read(0, 2'd1, 1'b0, 8'h00, 1'b0, -1, -1, 1'b0, "rearm");
        chk_rearm = 1'b0;

        // External fuse on an ARMED cell.
        do_init(5, 8'hAB, 2'd1, 1'b0, 1'b0, "fuse5");
        @(negedge clk);
        fuse_blow[5] = 1'b1;
        @(negedge clk);
        fuse_blow = '0;
        check("fuse5_killed", killed[5], 1'b1);
        check("fuse5_collapsed", collapsed[5], 1'b0);
        check("fuse5_no_fire", fuse_fire, 1'b0);
        do_read(5, 2'd1, 1'b0, 8'h00, 1'b0, -1, -1, 1'b0, "fuse5_rd");
        do_init(5, 8'h12, 2'd1, 1'b1, 1'b1, "fuse5_reinit");

        // Init colliding with MEASURE of the same cell: collapse wins.
        do_init(2, 8'h42, 2'd2, 1'b0, 1'b0, "coll2");
        do_read(2, 2'd2, 1'b1, 8'h42, 1'b1, 2, -1, 1'b1, "coll2_rd");
        check("coll2_collapsed", collapsed[2], 1'b1);
        // Init to another cell during MEASURE proceeds (loads 0x99, basis 2).
        do_read(2, 2'd2, 1'b0, 8'h00, 1'b0, 4, -1, 1'b0, "coll2_rd2");
        do_read(4, 2'd2, 1'b1, 8'h99, 1'b1, -1, -1, 1'b0, "inj4_rd");

        // Fuse colliding with MEASURE: FUSED wins, noise, no fire.
        do_init(6, 8'h66, 2'd3, 1'b0, 1'b0, "fcoll6");
        do_read(6, 2'd3, 1'b0, 8'h00, 1'b0, -1, 6, 1'b0, "fcoll6_rd");
        check("fcoll6_killed", killed[6], 1'b1);
        check("fcoll6_collapsed", collapsed[6], 1'b0);

        // Backpressure: response held stable for 5 cycles.
        resp_ready = 1'b0;
        do_read(3, 2'd2, 1'b0, 8'h00, 1'b0, -1, -1, 1'b0, "bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), resp_valid, 1'b1);
            check($sformatf("bp%0d_rd_ready", k), rd_ready, 1'b0);
            check($sformatf("bp%0d_data", k), resp_data, last_exp_data);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", resp_valid, 1'b0);

        // Reset while a response is pending.
        resp_ready = 1'b0;
        do_read(7, 2'd0, 1'b0, 8'h00, 1'b0, -1, -1, 1'b0, "rst_resp");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        resp_ready = 1'b1;
        reset_n = 1'b1;
        check_reset_outputs("rst_mid_rel");
        do_read(3, 2'd2, 1'b0, 8'h00, 1'b0, -1, -1, 1'b0, "post_rst_rd");
        check("post_rst_collapsed", collapsed, '0);
        do_init(5, 8'hE1, 2'd1, 1'b0, 1'b0, "post_rst5");
        do_read(5, 2'd1, 1'b1, 8'hE1, 1'b1, -1, -1, 1'b0, "post_rst5_rd");

        // Init and fuse on the same cell in one cycle: FUSED wins, init_err.
        @(negedge clk);
        init = 1'b1; init_addr = 3'd1; init_value = 8'h3C; init_basis = 2'd0;
        fuse_blow[1] = 1'b1;
        @(negedge clk);
        init = 1'b0; fuse_blow = '0;
        check("fi1_init_err", init_err, 1'b1);
        check("fi1_killed", killed[1], 1'b1);
        check("fi1_collapsed", collapsed[1], 1'b0);

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
